pdm_tx_modulator: RTL
=====================

# pdm_tx_modulator

Converts a stream of signed 16-bit PCM samples into a 1-bit PDM bitstream plus its PDM clock, using a second-order sigma-delta modulator with zero-order-hold interpolation. It is the transmit counterpart of the PDM microphone receive chain (CIC decimator plus FIR compensator). It drives PDM speakers or amplifiers. It also provides a loopback stimulus source for the receive chain. It runs on the 100 MHz fabric clock and generates the 2 MHz PDM clock internally.

## Interface
- CLK_DIV, 50: fabric clocks per PDM bit period; must be even and ≥ 4.
- OSR, 64: PDM bits per PCM sample (sample rate = f_clk / (CLK_DIV·OSR)).
- DATA_W, 16: PCM sample width, two's complement.
- ACC_W, 24: integrator width, signed.

Ports:
- clk  in  1  fabric clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  modulator run enable.
- in_data  in  DATA_W  signed PCM sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  holding register empty; sample accepted when in_valid && in_ready.
- pdm_clk_out  out  1  PDM clock, 50% duty, f_clk/CLK_DIV.
- pdm_out  out  1  PDM data; changes only with pdm_clk_out falling, stable at its rising edge.
- sample_tick  out  1  one-clk pulse when a new PCM sample is loaded into the modulator.
- underflow  out  1  one-clk pulse when a load finds the holding register empty.

## Operation
- Reset values: pdm_clk_out=0, pdm_out=0, in_ready=0 (goes 1 the first cycle after reset deasserts), sample_tick=0, underflow=0. Reset clears the integrators, counters, current sample (0) and holding register (empty).
- Divider: div_cnt runs 0..CLK_DIV-1 and wraps. pdm_clk_out is registered; it is 1 for div_cnt < CLK_DIV/2 and 0 otherwise. The divider runs regardless of enable.
- bit_tick: the cycle with div_cnt == CLK_DIV/2-1. On it the modulator steps, and pdm_out updates on the next edge, coincident with the pdm_clk_out falling edge.
- Holding register: one entry. An accept sets it full and drops in_ready next cycle. A load empties it and raises in_ready next cycle.
- Load: on a bit_tick with bit_cnt == OSR-1, bit_cnt wraps to 0.
  - If the holding register is full: current sample ← holding, pulse sample_tick.
  - If empty: current sample is kept (repeat), pulse underflow; sample_tick is not pulsed.
  - A sample accepted in the same cycle as a load is not visible to that load. It counts as an underflow and is used at the next load.
- Modulator (CIFB, per bit_tick), with x the sign-extended current sample, FS = 2^(DATA_W-1) and fb = pdm ? +FS : −FS:
  - i1 ← sat(i1 + x − fb)
  - i2 ← sat(i2 + i1 − fb)
  - pdm ← (i2_next ≥ 0)
  - fb uses the previous pdm.
  - sat clamps to ±(2^(ACC_W-1)−1).
  - Inputs with |x| ≤ 0.75·FS are guaranteed stable. Larger inputs rely on saturation, with no other protection.
- enable=0:
  - Integrators are held at 0 and pdm_out toggles every bit_tick (1,0,1,0…, the zero-level pattern).
  - bit_cnt is held at 0, so no loads, no sample_tick and no underflow occur.
  - The holding register can still accept one sample.
- enable rising: it takes effect at the next bit_tick; the first load occurs OSR bit_ticks later.

## Timing
- Input to output latency: the accepted sample enters the modulator at the next load boundary, which is at most OSR·CLK_DIV + 1 clks after accept.
- pdm_out changes only in the cycle where pdm_clk_out goes 1→0. Setup/hold to the rising edge is CLK_DIV/2 clks each.
- sample_tick and underflow are registered. They coincide with the pdm_out update that uses the new or repeated sample.
- Reset mid-operation takes effect on the next clk edge: outputs return to reset values and a partially output sample is discarded.
- in_ready never depends combinationally on in_valid.

## Structure
- Package pdm_pkg holds:
  - the default constants CLK_DIV, OSR, DATA_W, ACC_W;
  - FS;
  - a saturation function for ACC_W.
- Sub-module sigma_delta2_core holds the integrators, the quantizer and the feedback. Its interface is step, clear, x and pdm. The top level keeps the divider, bit/sample counters, holding register and handshake.

## Test plan
- Reset: hold reset 5 clks → all outputs 0 during reset; in_ready=1 the cycle after release; pdm_clk_out period 50 clks, high 25.
- Zero input, enable=1 → pdm_out alternates 1/0 every bit; exactly 2048 ones in any 4096-bit window after settling (±2).
- Constant x=+24576 (0.75 FS) → ones density 0.875 ±0.005 over 8192 bits. x=−24576 → 0.125 ±0.005. No integrator saturation.
- Backpressure: assert in_valid continuously → exactly one accept per 3200 clks; sample_tick pulses every 3200 clks; underflow never pulses.
- Underflow: stop in_valid after two samples → underflow pulses at the next load; the last sample repeats, verified by unchanged ones density; resuming in_valid → sample_tick again at the following load.
- Loopback: drive a 1 kHz sine at 0.5 FS into the PDM receive chain (CIC+FIR) → recovered tone at 1 kHz. Amplitude within 1 dB of the expected filter gain; spurs below −60 dBc.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM transmit modulator.
// Holds the default geometry, the full-scale value and the integrator clamp.
package pdm_pkg;

    localparam int DEFAULT_CLK_DIV = 50;
    localparam int DEFAULT_OSR     = 64;
    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_ACC_W   = 24;
    localparam int FS              = 1 << (DEFAULT_DATA_W - 1);

    // Symmetric clamp to +/-(2^(accW-1)-1) on a wide signed intermediate.
    function automatic logic signed [63:0] satAcc(input logic signed [63:0] value,
                                                  input int accW);
        logic signed [63:0] limit;
        limit = (64'sd1 <<< (accW - 1)) - 64'sd1;
        if (value > limit) begin
            satAcc = limit;
        end else if (value < -limit) begin
            satAcc = -limit;
        end else begin
            satAcc = value;
        end
    endfunction

endpackage

// File: rtl/pdm_tx_modulator_core.sv
// Second-order CIFB sigma-delta core: two clamped integrators, 1-bit quantizer, feedback.
// Advances once per step; with clear it holds the integrators at zero and toggles pdm.
module sigma_delta2_core
    import pdm_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] x,
    output logic                     pdm
);

    localparam logic signed [63:0] FULL_SCALE = 64'sd1 <<< (DATA_W - 1);

    logic signed [ACC_W-1:0] i1_q, i1_d;
    logic signed [ACC_W-1:0] i2_q, i2_d;
    logic                    pdm_q, pdm_d;
    logic signed [63:0]      xExt, i1Ext, i2Ext, fb, sum1, sum2;

    // The second integrator consumes the freshly updated first integrator.
    always_comb begin
        xExt  = {{(64 - DATA_W){x[DATA_W-1]}}, x};
        i1Ext = {{(64 - ACC_W){i1_q[ACC_W-1]}}, i1_q};
        i2Ext = {{(64 - ACC_W){i2_q[ACC_W-1]}}, i2_q};
        fb    = pdm_q ? FULL_SCALE : -FULL_SCALE;
        sum1  = satAcc(i1Ext + xExt - fb, ACC_W);
        sum2  = satAcc(i2Ext + sum1 - fb, ACC_W);
        i1_d  = i1_q;
        i2_d  = i2_q;
        pdm_d = pdm_q;
        if (step) begin
            if (clear) begin
                i1_d  = '0;
                i2_d  = '0;
                pdm_d = !pdm_q;
            end else begin
                i1_d  = sum1[ACC_W-1:0];
                i2_d  = sum2[ACC_W-1:0];
                pdm_d = !sum2[63];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i1_q  <= '0;
            i2_q  <= '0;
            pdm_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            pdm_q <= pdm_d;
        end
    end

    assign pdm = pdm_q;

endmodule

// File: rtl/pdm_tx_modulator.sv
// PCM-to-PDM transmitter: clock divider, bit/sample counters, one-entry holding
// register with ready/valid handshake, and the second-order sigma-delta core.
module pdm_tx_modulator
    import pdm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int OSR     = DEFAULT_OSR,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ACC_W   = DEFAULT_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     pdm_clk_out,
    output logic                     pdm_out,
    output logic                     sample_tick,
    output logic                     underflow
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(OSR);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_TICK = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

    logic [DIV_W-1:0]         divCnt_q, divCnt_d;
    logic [BIT_W-1:0]         bitCnt_q, bitCnt_d;
    logic                     pdmClk_q, pdmClk_d;
    logic                     holdFull_q, holdFull_d;
    logic signed [DATA_W-1:0] holdData_q, holdData_d;
    logic signed [DATA_W-1:0] curSample_q, curSample_d;
    logic                     inReady_q, inReady_d;
    logic                     sampleTick_q, sampleTick_d;
    logic                     underflow_q, underflow_d;
    logic                     bitTick, load, accept;
    logic signed [DATA_W-1:0] coreX;
    logic                     pdmBit;

    // A load sees only the holding state from before this edge, so a same-cycle
    // accept is deferred to the following load.
    always_comb begin
        divCnt_d     = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + 1'b1;
        pdmClk_d     = (divCnt_d < DIV_HALF);
        bitTick      = (divCnt_q == DIV_TICK);
        accept       = in_valid && inReady_q;
        load         = bitTick && enable && (bitCnt_q == BIT_LAST);
        bitCnt_d     = bitCnt_q;
        curSample_d  = curSample_q;
        coreX        = curSample_q;
        holdFull_d   = holdFull_q;
        holdData_d   = holdData_q;
        if (bitTick) begin
            if (!enable || load) begin
                bitCnt_d = '0;
            end else begin
                bitCnt_d = bitCnt_q + 1'b1;
            end
        end
        if (load && holdFull_q) begin
            curSample_d = holdData_q;
            coreX       = holdData_q;
            holdFull_d  = 1'b0;
        end
        if (accept) begin
            holdFull_d = 1'b1;
            holdData_d = in_data;
        end
        sampleTick_d = load && holdFull_q;
        underflow_d  = load && !holdFull_q;
        inReady_d    = !holdFull_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt_q     <= '0;
            bitCnt_q     <= '0;
            pdmClk_q     <= 1'b0;
            holdFull_q   <= 1'b0;
            holdData_q   <= '0;
            curSample_q  <= '0;
            inReady_q    <= 1'b0;
            sampleTick_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            divCnt_q     <= divCnt_d;
            bitCnt_q     <= bitCnt_d;
            pdmClk_q     <= pdmClk_d;
            holdFull_q   <= holdFull_d;
            holdData_q   <= holdData_d;
            curSample_q  <= curSample_d;
            inReady_q    <= inReady_d;
            sampleTick_q <= sampleTick_d;
            underflow_q  <= underflow_d;
        end
    end

    sigma_delta2_core #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .step (bitTick),
        .clear(!enable),
        .x    (coreX),
        .pdm  (pdmBit)
    );

    assign in_ready    = inReady_q;
    assign pdm_clk_out = pdmClk_q;
    assign pdm_out     = pdmBit;
    assign sample_tick = sampleTick_q;
    assign underflow   = underflow_q;

endmodule
